// File: rtl/alu4_pkg.sv
// Types and constants shared by the 4-bit shifter and its result stage.
// Each stored entry carries the result, its select and the flags derived at capture time.
package alu4_pkg;

    localparam logic [1:0] SEL_LEFT  = 2'b00;
    localparam logic [1:0] SEL_RIGHT = 2'b01;
    localparam logic [1:0] SEL_ARITH = 2'b10;
    localparam logic [1:0] SEL_PASS  = 2'b11;

    typedef struct packed {
        logic [3:0] result;
        logic [1:0] select;
        logic       zero;
        logic       neg;
        logic       range_flag;
    } entry_t;

    // Flags are fixed when the entry is captured, so later reads never recompute them.
    // Amounts 4..15 push every bit out unless the shifter is in pass-through mode.
    function automatic entry_t make_entry(input logic [3:0] result,
                                          input logic [3:0] amount,
                                          input logic [1:0] select);
        entry_t e;
        e.result     = result;
        e.select     = select;
        e.zero       = (result == 4'd0);
        e.neg        = result[3];
        e.range_flag = (amount > 4'd3) && (select != SEL_PASS);
        return e;
    endfunction

endpackage

// File: rtl/shift_result_stage_if.sv
// Upstream (shifter) and downstream (consumer) handshake bundle of the shift result stage.
interface shift_result_stage_if #(parameter int CNT_W = 8);

    logic             in_valid;
    logic             in_ready;
    logic [3:0]       in_result;
    logic [3:0]       in_amount;
    logic [1:0]       in_select;
    logic             out_valid;
    logic             out_ready;
    logic [3:0]       out_result;
    logic [1:0]       out_select;
    logic             out_zero;
    logic             out_neg;
    logic             out_range;
    logic [CNT_W-1:0] out_count;
    logic             full;
    logic             empty;

    modport master (
        output in_valid, in_result, in_amount, in_select, out_ready,
        input  in_ready, out_valid, out_result, out_select, out_zero,
        input  out_neg, out_range, out_count, full, empty
    );

    modport slave (
        input  in_valid, in_result, in_amount, in_select, out_ready,
        output in_ready, out_valid, out_result, out_select, out_zero,
        output out_neg, out_range, out_count, full, empty
    );

endinterface

// File: rtl/sync_fifo_ptr.sv
// Read/write pointers and occupancy for a power-of-two synchronous FIFO.
// A push while full is ignored and a pop while empty is ignored, so callers may pass raw requests.
module sync_fifo_ptr #(
    parameter  int DEPTH = 2,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          push,
    input  logic          pop,
    output logic [AW-1:0] wr_ptr,
    output logic [AW-1:0] rd_ptr,
    output logic          full,
    output logic          empty
);

    logic [AW:0] occupancy;
    logic        push_ok;
    logic        pop_ok;

    assign full    = (occupancy == (AW+1)'(DEPTH));
    assign empty   = (occupancy == '0);
    assign push_ok = push && !full;
    assign pop_ok  = pop && !empty;

    // Pointers wrap naturally at DEPTH; occupancy holds when push and pop coincide.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            occupancy <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop_ok) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            if (push_ok && !pop_ok) begin
                occupancy <= occupancy + 1'b1;
            end else if (pop_ok && !push_ok) begin
                occupancy <= occupancy - 1'b1;
            end
        end
    end

endmodule

// File: rtl/shift_result_stage.sv
// Registered output stage behind the 4-bit shifter: captures results with flags,
// buffers them in a small FIFO and hands them to the consumer over valid/ready.
module shift_result_stage
    import alu4_pkg::*;
#(
    parameter  int DEPTH = 2,
    parameter  int CNT_W = 8,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    shift_result_stage_if.slave  bus
);

    entry_t           mem [DEPTH];
    entry_t           head;
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW-1:0]    head_idx;
    logic             full;
    logic             empty;
    logic             push;
    logic             pop;
    logic [CNT_W-1:0] count;

    assign push = bus.in_valid && !full;
    assign pop  = !empty && bus.out_ready;

    sync_fifo_ptr #(.DEPTH(DEPTH)) u_ptr (
        .clk    (clk),
        .rst_n  (rst_n),
        .push   (push),
        .pop    (pop),
        .wr_ptr (wr_ptr),
        .rd_ptr (rd_ptr),
        .full   (full),
        .empty  (empty)
    );

    // Storage is cleared on reset so the head reads as all zeros until the first push.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (push) begin
            mem[wr_ptr] <= make_entry(bus.in_result, bus.in_amount, bus.in_select);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            count <= '0;
        end else if (pop) begin
            count <= count + 1'b1;
        end
    end

    // When empty, show the slot just behind rd_ptr: the last entry delivered, which
    // a push into the empty FIFO cannot overwrite, so out_* hold their value.
    assign head_idx = empty ? (rd_ptr - 1'b1) : rd_ptr;
    assign head     = mem[head_idx];

    assign bus.in_ready   = !full;
    assign bus.out_valid  = !empty;
    assign bus.out_result = head.result;
    assign bus.out_select = head.select;
    assign bus.out_zero   = head.zero;
    assign bus.out_neg    = head.neg;
    assign bus.out_range  = head.range_flag;
    assign bus.out_count  = count;
    assign bus.full       = full;
    assign bus.empty      = empty;

endmodule
